// File: rtl/pzcorebus_error_slave_pkg.sv
// Helpers for the CoreBus error slave: read response beat count.
package pzcorebus_error_slave_pkg;

    // Number of response beats needed to cover a read that starts at word
    // 'offset' within a data beat and spans 'length' 32-bit words, given
    // 'units' words per beat.
    function automatic int unsigned calc_read_beats(
        input int unsigned offset,
        input int unsigned length,
        input int unsigned units
    );
        return (offset + length + units - 1) / units;
    endfunction

endpackage

// File: rtl/pzcorebus_pkg.sv
// Shared CoreBus definitions: command/response encodings and command bit positions.
package pzcorebus_pkg;

    // Command type bit positions
    localparam int PZCOREBUS_WITH_DATA_BIT  = 2;
    localparam int PZCOREBUS_NON_POSTED_BIT = 3;

    // Command type encodings: {non_posted, with_data, kind[1:0]}
    typedef enum logic [3:0] {
        PZCOREBUS_NULL                  = 4'b0_000,
        PZCOREBUS_MESSAGE               = 4'b0_001,
        PZCOREBUS_BROADCAST             = 4'b0_100,
        PZCOREBUS_WRITE                 = 4'b0_101,
        PZCOREBUS_ATOMIC                = 4'b0_110,
        PZCOREBUS_FULL_WRITE            = 4'b0_111,
        PZCOREBUS_MESSAGE_NON_POSTED    = 4'b1_000,
        PZCOREBUS_READ                  = 4'b1_001,
        PZCOREBUS_WRITE_NON_POSTED      = 4'b1_101,
        PZCOREBUS_ATOMIC_NON_POSTED     = 4'b1_110,
        PZCOREBUS_FULL_WRITE_NON_POSTED = 4'b1_111
    } pzcorebus_command_type_e;

    // Response type encodings
    typedef enum logic {
        PZCOREBUS_RESPONSE           = 1'b0,
        PZCOREBUS_RESPONSE_WITH_DATA = 1'b1
    } pzcorebus_response_type_e;

endpackage

// File: rtl/pzcorebus_error_slave.sv
// Default-target CoreBus responder: drains write data and answers every
// non-posted command with an error response (full-length burst for reads).
module pzcorebus_error_slave #(
    parameter int ID_WIDTH            = 12,
    parameter int ADDRESS_WIDTH       = 32,
    parameter int DATA_WIDTH          = 256,
    parameter int MAX_LENGTH          = 256,
    parameter int LENGTH_WIDTH        = $clog2(MAX_LENGTH),
    parameter int RESPONSE_INFO_WIDTH = 1
)(
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_mcmd_valid,
    output logic                           o_scmd_accept,
    input  logic [3:0]                     i_mcmd,
    input  logic [ID_WIDTH-1:0]            i_mid,
    input  logic [ADDRESS_WIDTH-1:0]       i_maddr,
    input  logic [LENGTH_WIDTH-1:0]        i_mlength,
    input  logic                           i_mdata_valid,
    output logic                           o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]          i_mdata,
    input  logic [DATA_WIDTH/8-1:0]        i_mdata_byteen,
    input  logic                           i_mdata_last,
    output logic                           o_sresp_valid,
    input  logic                           i_mresp_accept,
    output logic                           o_sresp,
    output logic [ID_WIDTH-1:0]            o_sid,
    output logic                           o_serror,
    output logic [DATA_WIDTH-1:0]          o_sdata,
    output logic [RESPONSE_INFO_WIDTH-1:0] o_sinfo,
    output logic [1:0]                     o_sresp_last
);

    import pzcorebus_pkg::*;
    import pzcorebus_error_slave_pkg::*;

    localparam int UNITS        = DATA_WIDTH / 32;
    localparam int OFFSET_WIDTH = $clog2(DATA_WIDTH / 8) - 2;
    localparam int BEAT_WIDTH   = LENGTH_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                   state_q;
    state_e                   state_d;
    logic [ID_WIDTH-1:0]      sid_q;
    logic [ID_WIDTH-1:0]      sid_d;
    pzcorebus_response_type_e sresp_q;
    pzcorebus_response_type_e sresp_d;
    logic                     non_posted_q;
    logic                     non_posted_d;
    logic [BEAT_WIDTH-1:0]    beats_q;
    logic [BEAT_WIDTH-1:0]    beats_d;

    logic [31:0]              addr_offset;
    logic [31:0]              read_length;
    logic [BEAT_WIDTH-1:0]    read_beats;
    logic                     last_beat;
    logic                     cmd_hs;
    logic                     data_last_hs;
    logic                     resp_hs;
    logic                     unused_inputs;

    // Payload of the request-data channel and the upper address bits carry no meaning here
    assign unused_inputs = ^{i_mdata, i_mdata_byteen, i_maddr};

    // Word offset of the start address within one data beat
    if (OFFSET_WIDTH > 0) begin : g_addr_offset
        assign addr_offset = 32'(i_maddr[OFFSET_WIDTH+1:2]);
    end else begin : g_no_addr_offset
        assign addr_offset = '0;
    end

    assign read_length = (i_mlength == '0) ? 32'(MAX_LENGTH) : 32'(i_mlength);
    assign read_beats  = BEAT_WIDTH'(calc_read_beats(addr_offset, read_length, UNITS));

    assign cmd_hs       = i_mcmd_valid && o_scmd_accept;
    assign data_last_hs = i_mdata_valid && o_sdata_accept && i_mdata_last;
    assign resp_hs      = o_sresp_valid && i_mresp_accept;
    assign last_beat    = (state_q == RESP) && (beats_q == BEAT_WIDTH'(1));

    assign o_scmd_accept  = i_rst_n && (state_q == IDLE);
    assign o_sdata_accept = (state_q == DRAIN);
    assign o_sresp_valid  = (state_q == RESP);
    assign o_serror       = (state_q == RESP);
    assign o_sresp        = sresp_q;
    assign o_sid          = sid_q;
    assign o_sdata        = '0;
    assign o_sinfo        = '0;
    assign o_sresp_last   = {last_beat, last_beat};

    // Next-state decode plus capture of command ID, type and beat count
    always_comb begin
        state_d      = state_q;
        sid_d        = sid_q;
        sresp_d      = sresp_q;
        non_posted_d = non_posted_q;
        beats_d      = beats_q;
        case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    if (i_mcmd == PZCOREBUS_READ) begin
                        state_d = RESP;
                        sid_d   = i_mid;
                        sresp_d = PZCOREBUS_RESPONSE_WITH_DATA;
                        beats_d = read_beats;
                    end else if (i_mcmd[PZCOREBUS_WITH_DATA_BIT]) begin
                        state_d      = DRAIN;
                        sid_d        = i_mid;
                        non_posted_d = i_mcmd[PZCOREBUS_NON_POSTED_BIT];
                    end else if (i_mcmd[PZCOREBUS_NON_POSTED_BIT]) begin
                        state_d = RESP;
                        sid_d   = i_mid;
                        sresp_d = PZCOREBUS_RESPONSE;
                        beats_d = BEAT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (data_last_hs) begin
                    if (non_posted_q) begin
                        state_d = RESP;
                        sresp_d = PZCOREBUS_RESPONSE;
                        beats_d = BEAT_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (resp_hs) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beats_d = beats_q - BEAT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, capture and beat-counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            sid_q        <= '0;
            sresp_q      <= PZCOREBUS_RESPONSE;
            non_posted_q <= 1'b0;
            beats_q      <= '0;
        end else begin
            state_q      <= state_d;
            sid_q        <= sid_d;
            sresp_q      <= sresp_d;
            non_posted_q <= non_posted_d;
            beats_q      <= beats_d;
        end
    end

endmodule

// File: doc/pzcorebus_error_slave.md
# pzcorebus_error_slave

Default-target responder on a CoreBus fabric. It terminates every command routed to an unmapped address region. Write data is drained, and every non-posted command gets an error response. Reads return a full-length error burst so upstream masters never hang. The block sits downstream of the address decoder/router and upstream of the response arbiter, on the memory-profile (MEMORY_H) command, request-data and response channels.

## Interface
Parameters:
- ID_WIDTH, 12: width of command/response ID.
- ADDRESS_WIDTH, 32: command address width.
- DATA_WIDTH, 256: data width in bits, a multiple of 32 and at least 32.
- MAX_LENGTH, 256: maximum burst length in 32-bit units.
- LENGTH_WIDTH, $clog2(MAX_LENGTH): width of i_mlength.
- RESPONSE_INFO_WIDTH, 1: width of o_sinfo.

Ports:
- i_clk, input, 1: clock; single clock domain.
- i_rst_n, input, 1: reset; asynchronous, active-low.
- i_mcmd_valid, input, 1: command valid.
- o_scmd_accept, output, 1: command accept.
- i_mcmd, input, 4: command type; bit3 = non-posted, bit2 = has request data.
- i_mid, input, ID_WIDTH: command ID.
- i_maddr, input, ADDRESS_WIDTH: command address.
- i_mlength, input, LENGTH_WIDTH: length in 32-bit units; 0 encodes MAX_LENGTH.
- i_mdata_valid, input, 1: request data valid.
- o_sdata_accept, output, 1: request data accept.
- i_mdata, input, DATA_WIDTH: request data; ignored.
- i_mdata_byteen, input, DATA_WIDTH/8: request byte enable; ignored.
- i_mdata_last, input, 1: last request-data beat.
- o_sresp_valid, output, 1: response valid.
- i_mresp_accept, input, 1: response accept.
- o_sresp, output, 1: response type; 0 = RESPONSE, 1 = RESPONSE_WITH_DATA.
- o_sid, output, ID_WIDTH: response ID, equal to the captured i_mid.
- o_serror, output, 1: error flag; always 1 when o_sresp_valid is high.
- o_sdata, output, DATA_WIDTH: response data; always 0.
- o_sinfo, output, RESPONSE_INFO_WIDTH: response info; always 0.
- o_sresp_last, output, 2: bit0 = last beat of burst, bit1 = last response of command.

## Operation
States: IDLE, DRAIN, RESP.

IDLE:
- o_scmd_accept = 1 (forced 0 while i_rst_n is low).
- On the command handshake, capture i_mid, the command type and the beat count.
- READ (1_001) goes to RESP with o_sresp = 1 and the computed beat count.
- Any command with bit2 = 1 (write, full write, broadcast, atomic; posted or non-posted) goes to DRAIN.
- Non-posted command with bit2 = 0 (message non-posted) goes to RESP with o_sresp = 0 and one beat.
- Posted command with bit2 = 0 (message, NULL) is dropped; the state stays IDLE.

DRAIN:
- o_sdata_accept = 1; every offered beat is consumed.
- On a handshake with i_mdata_last = 1: non-posted commands go to RESP (o_sresp = 0, one beat); posted commands go to IDLE.

RESP:
- o_sresp_valid = 1; o_serror = 1.
- The beat counter decrements on each response handshake.
- On the final beat, o_sresp_last = 2'b11; on earlier beats it is 2'b00.
- The handshake on the final beat goes to IDLE.

Read beat count:
- U = DATA_WIDTH/32.
- off = i_maddr[$clog2(DATA_WIDTH/8)-1:2].
- len = (i_mlength == 0) ? MAX_LENGTH : i_mlength.
- beats = (off + len + U - 1) / U.
- Computed at LENGTH_WIDTH+2 bits; the result never exceeds MAX_LENGTH/U + 1.

Request data arriving before or while the block is in IDLE is not accepted until the block is in DRAIN.

## Timing
- Reset values: o_scmd_accept = 0 during reset; all other outputs 0; state = IDLE.
- o_scmd_accept and o_sdata_accept are decoded from the registered state with no input dependence; o_sresp_valid and the response payload are registered.
- Read: first response beat is valid the cycle after the command handshake.
- Non-posted write: response is valid the cycle after the i_mdata_last handshake.
- Response payload is stable while o_sresp_valid = 1 and i_mresp_accept = 0.
- After a handshake, the next beat is presented in the following cycle, or o_sresp_valid drops if that was the last beat.
- Throughput: the next command is accepted no earlier than the cycle after the last response handshake or the last drain handshake. For posted no-data commands, accept stays high, giving one command per cycle.
- Reset asserted mid-burst or mid-drain: return to IDLE immediately; outstanding responses are discarded; no partial beat is emitted after reset release.

## Structure
- Shared package pzcorebus_pkg holds the command type enum, the bit-position constants (data bit 2, non-posted bit 3) and the response type enum.
- The block package holds the beat-count function (address offset + length → beats).
- No sub-module; the FSM, beat counter and capture registers live in one module.

## Test plan
All scenarios use DATA_WIDTH = 256 (U = 8).
- Read, id 0x5, addr 0x00, length 8 → one beat next cycle: sresp = 1, serror = 1, sid = 0x5, sdata = 0, last = 2'b11.
- Read, addr 0x1C (off = 7), length 2 → two beats with last = 2'b00 then 2'b11; length 0 at addr 0 → 32 beats.
- Non-posted write, length 16, two data beats → sdata_accept for both beats; one response (sresp = 0, serror = 1, last = 2'b11) the cycle after mdata_last.
- Posted write with 3 data beats, then message posted → all data drained, no response; scmd_accept reasserts the cycle after mdata_last.
- Read of 4 beats with mresp_accept held low for 5 cycles on beat 2 → valid, sid and last held stable; exactly 4 handshakes total.
- Reset asserted during beat 3 of 8 → all outputs 0 at once; after release, a new read id 0x9 gets a correct single response.
